// File: rtl/npu_seq_pkg.sv
// npu_seq_pkg: shared states, latched config and sizing helpers for the conv sequencer
package npu_seq_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, DONE} seq_state_e;

    typedef struct packed {
        logic bcast;
        logic pe_mode;
    } seq_cfg_t;

    function automatic int k2(input int k);
        return k * k;
    endfunction

    function automatic int sel_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/npu_seq_tap_counter.sv
// npu_seq_tap_counter: loadable up/down counter used for the MAC tap index and the DRAIN countdown
module npu_seq_tap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         up_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_d_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // a load takes priority over counting; the next value is exported so callers can register from it
    always_comb cnt_d = load_i ? load_val_i : !en_i ? cnt_q : up_i ? cnt_q + W'(1) : cnt_q - W'(1);

    // count register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/npu_conv_sequencer.sv
// npu_conv_sequencer: steps one K_SIZE x K_SIZE pass over the PE array; NPU_SEQ_PERF_EN adds a busy-cycle counter
module npu_conv_sequencer
    import npu_seq_pkg::*;
#(
    parameter int N               = 10,
    parameter int K_SIZE          = 3,
    parameter int PIPE_LAT        = 2,
    parameter int SEL_MUX_A_WIDTH = sel_w(k2(K_SIZE)),
    parameter int SEL_MUX_B_WIDTH = sel_w(2 * k2(K_SIZE))
`ifdef NPU_SEQ_PERF_EN
    , parameter int PERF_W        = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cfg_bcast,
    input  logic                       cfg_acc_clear,
    input  logic                       cfg_pe_mode,
    input  logic [N-1:0]               cfg_pe_mask,
    output logic [N-1:0]               pe_en,
    output logic [N-1:0]               pe_mode_sel,
    output logic [N-1:0]               pe_reg_reset,
    output logic [SEL_MUX_A_WIDTH-1:0] pe_mux_a_sel,
    output logic [SEL_MUX_B_WIDTH-1:0] pe_mux_b_sel,
    output logic                       busy,
    output logic                       done
`ifdef NPU_SEQ_PERF_EN
    , output logic [PERF_W-1:0]        perf_cycles
`endif
);

    localparam int K2   = k2(K_SIZE);
    localparam int CMAX = K2 > PIPE_LAT ? K2 : PIPE_LAT;
    localparam int CW   = sel_w(CMAX);
    localparam logic [CW-1:0] LAST_TAP = CW'(K2 - 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(PIPE_LAT > 0 ? PIPE_LAT - 1 : 0);

    seq_state_e state_q, state_d;
    seq_cfg_t   cfg_q, cfg_d;
    logic [N-1:0] mask_q, mask_d;
    logic accept;
    logic [CW-1:0] cnt_q, cnt_d, cnt_val;
    logic cnt_load, cnt_en, cnt_up;
    logic [N-1:0] en_q, en_d, mode_q, mode_d, rst_q, rst_d;
    logic [SEL_MUX_A_WIDTH-1:0] a_q, a_d;
    logic [SEL_MUX_B_WIDTH-1:0] b_q, b_d;
    logic busy_q, busy_d, done_q, done_d, hold;

    npu_seq_tap_counter #(.W(CW)) u_tap_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .en_i      (cnt_en),
        .up_i      (cnt_up),
        .cnt_o     (cnt_q),
        .cnt_d_o   (cnt_d)
    );

    // next state, config capture and counter control; abort beats everything, start only counts in IDLE/DONE
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (abort) state_d = IDLE;
        else case (state_q)
            IDLE, DONE: begin
                accept  = start;
                state_d = start ? (cfg_acc_clear ? CLEAR : MAC) : IDLE;
            end
            CLEAR: state_d = MAC;
            MAC:   if (cnt_q == LAST_TAP) state_d = (PIPE_LAT == 0) ? DONE : DRAIN;
            DRAIN: if (cnt_q == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
        cfg_d    = accept ? '{bcast: cfg_bcast, pe_mode: cfg_pe_mode} : cfg_q;
        mask_d   = accept ? cfg_pe_mask : mask_q;
        cnt_load = state_d != state_q;
        cnt_val  = state_d == DRAIN ? DRAIN_LD : '0;
        cnt_en   = state_q == MAC || state_q == DRAIN;
        cnt_up   = state_q == MAC;
    end

    // outputs are decoded from the next state so they can be registered without adding latency
    always_comb begin
        hold   = state_d == DRAIN || state_d == DONE;
        en_d   = state_d == MAC ? mask_d : '0;
        mode_d = state_d == MAC ? mask_d & {N{cfg_d.pe_mode}} : '0;
        rst_d  = state_d == CLEAR ? mask_d : '0;
        a_d    = state_d == MAC ? SEL_MUX_A_WIDTH'(cnt_d) : hold ? a_q : '0;
        b_d    = state_d == MAC ? SEL_MUX_B_WIDTH'(cnt_d) + (cfg_d.bcast ? SEL_MUX_B_WIDTH'(K2) : '0) : hold ? b_q : '0;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // state, latched config and output registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            mask_q  <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            rst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            mask_q  <= mask_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            rst_q   <= rst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end

    assign pe_en        = en_q;
    assign pe_mode_sel  = mode_q;
    assign pe_reg_reset = rst_q;
    assign pe_mux_a_sel = a_q;
    assign pe_mux_b_sel = b_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef NPU_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // the first busy cycle is counted on the accepting edge; counting stops once the pass returns to IDLE
    always_comb perf_d = accept ? PERF_W'(1) : (state_d != IDLE && perf_q != '1) ? perf_q + PERF_W'(1) : perf_q;

    // busy-cycle counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_npu_conv_sequencer.sv
// tb_npu_conv_sequencer: directed scenarios for the conv sequencer (PIPE_LAT=2 main DUT, PIPE_LAT=0 side DUT)
module tb_npu_conv_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, cfg_bcast = 1'b0, cfg_acc_clear = 1'b0, cfg_pe_mode = 1'b0;
    logic [9:0] cfg_pe_mask = '0;
    logic [9:0] pe_en, pe_mode_sel, pe_reg_reset, pe_en0, pe_mode_sel0, pe_reg_reset0;
    logic [3:0] mux_a, mux_a0;
    logic [4:0] mux_b, mux_b0;
    logic busy, done, busy0, done0;
`ifdef NPU_SEQ_PERF_EN
    logic [15:0] perf_cycles, perf_cycles0;
`endif
    int n_pass = 0, n_total = 0;

    wire [40:0] obs  = {pe_en, pe_mode_sel, pe_reg_reset, mux_a, mux_b, busy, done};
    wire [40:0] obs0 = {pe_en0, pe_mode_sel0, pe_reg_reset0, mux_a0, mux_b0, busy0, done0};

    always #5 clk = ~clk;

    npu_conv_sequencer #(.N(10), .K_SIZE(3), .PIPE_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_bcast(cfg_bcast), .cfg_acc_clear(cfg_acc_clear), .cfg_pe_mode(cfg_pe_mode), .cfg_pe_mask(cfg_pe_mask),
        .pe_en(pe_en), .pe_mode_sel(pe_mode_sel), .pe_reg_reset(pe_reg_reset),
        .pe_mux_a_sel(mux_a), .pe_mux_b_sel(mux_b), .busy(busy), .done(done)
`ifdef NPU_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    npu_conv_sequencer #(.N(10), .K_SIZE(3), .PIPE_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_bcast(cfg_bcast), .cfg_acc_clear(cfg_acc_clear), .cfg_pe_mode(cfg_pe_mode), .cfg_pe_mask(cfg_pe_mask),
        .pe_en(pe_en0), .pe_mode_sel(pe_mode_sel0), .pe_reg_reset(pe_reg_reset0),
        .pe_mux_a_sel(mux_a0), .pe_mux_b_sel(mux_b0), .busy(busy0), .done(done0)
`ifdef NPU_SEQ_PERF_EN
        , .perf_cycles(perf_cycles0)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        n_total++; if (obs !== 41'h0) $display("FAIL reset_held: got %h exp %h", obs, 41'h0); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++; if (obs !== 41'h0) $display("FAIL reset_idle: got %h exp %h", obs, 41'h0); else n_pass++;
`ifdef NPU_SEQ_PERF_EN
        n_total++; if (perf_cycles !== 16'd0) $display("FAIL reset_perf: got %0d exp 0", perf_cycles); else n_pass++;
`endif
    endtask

    task automatic test_clear_pass;
        logic [40:0] exp;
        start = 1; cfg_acc_clear = 1; cfg_bcast = 0; cfg_pe_mode = 0; cfg_pe_mask = 10'h3FF;
        tick(); start = 0;
        exp = {10'h0, 10'h0, 10'h3FF, 4'd0, 5'd0, 2'b10};
        n_total++; if (obs !== exp) $display("FAIL clear_cycle: got %h exp %h", obs, exp); else n_pass++;
        for (int t = 0; t < 9; t++) begin
            tick();
            exp = {10'h3FF, 10'h0, 10'h0, 4'(t), 5'(t), 2'b10};
            n_total++; if (obs !== exp) $display("FAIL clear_mac_t%0d: got %h exp %h", t, obs, exp); else n_pass++;
        end
        for (int d = 0; d < 2; d++) begin
            tick();
            exp = {30'h0, 4'd8, 5'd8, 2'b10};
            n_total++; if (obs !== exp) $display("FAIL clear_drain%0d: got %h exp %h", d, obs, exp); else n_pass++;
        end
        tick();
        exp = {30'h0, 4'd8, 5'd8, 2'b11};
        n_total++; if (obs !== exp) $display("FAIL clear_done_at13: got %h exp %h", obs, exp); else n_pass++;
        tick();
        n_total++; if (obs !== 41'h0) $display("FAIL clear_back_idle: got %h exp %h", obs, 41'h0); else n_pass++;
`ifdef NPU_SEQ_PERF_EN
        n_total++; if (perf_cycles !== 16'd13) $display("FAIL perf_cycles: got %0d exp 13", perf_cycles); else n_pass++;
`endif
    endtask

    task automatic test_bcast;
        logic [40:0] exp;
        start = 1; cfg_acc_clear = 0; cfg_bcast = 1; cfg_pe_mode = 0; cfg_pe_mask = 10'h3FF;
        for (int t = 0; t < 9; t++) begin
            tick(); start = 0;
            exp = {10'h3FF, 10'h0, 10'h0, 4'(t), 5'(t + 9), 2'b10};
            n_total++; if (obs !== exp) $display("FAIL bcast_mac_t%0d: got %h exp %h", t, obs, exp); else n_pass++;
        end
        for (int d = 0; d < 2; d++) begin
            tick();
            exp = {30'h0, 4'd8, 5'd17, 2'b10};
            n_total++; if (obs !== exp) $display("FAIL bcast_drain%0d: got %h exp %h", d, obs, exp); else n_pass++;
        end
        tick();
        exp = {30'h0, 4'd8, 5'd17, 2'b11};
        n_total++; if (obs !== exp) $display("FAIL bcast_done_at12: got %h exp %h", obs, exp); else n_pass++;
        tick();
        cfg_bcast = 0;
        n_total++; if (obs !== 41'h0) $display("FAIL bcast_idle: got %h exp %h", obs, 41'h0); else n_pass++;
    endtask

    task automatic test_mask;
        logic [40:0] exp;
        start = 1; cfg_acc_clear = 1; cfg_bcast = 0; cfg_pe_mode = 1; cfg_pe_mask = 10'h005;
        tick(); start = 0;
        exp = {10'h0, 10'h0, 10'h005, 4'd0, 5'd0, 2'b10};
        n_total++; if (obs !== exp) $display("FAIL mask_clear: got %h exp %h", obs, exp); else n_pass++;
        for (int t = 0; t < 9; t++) begin
            tick();
            exp = {10'h005, 10'h005, 10'h0, 4'(t), 5'(t), 2'b10};
            n_total++; if (obs !== exp) $display("FAIL mask_mac_t%0d: got %h exp %h", t, obs, exp); else n_pass++;
        end
        tick();
        exp = {30'h0, 4'd8, 5'd8, 2'b10};
        n_total++; if (obs !== exp) $display("FAIL mask_drain: got %h exp %h", obs, exp); else n_pass++;
        tick(); tick();
        exp = {30'h0, 4'd8, 5'd8, 2'b11};
        n_total++; if (obs !== exp) $display("FAIL mask_done: got %h exp %h", obs, exp); else n_pass++;
        tick();
        cfg_pe_mode = 0;
    endtask

    task automatic test_abort;
        logic [40:0] exp;
        logic seen_done;
        start = 1; cfg_acc_clear = 0; cfg_bcast = 0; cfg_pe_mask = 10'h3FF;
        for (int t = 0; t < 4; t++) begin
            tick(); start = 0;
        end
        exp = {10'h3FF, 10'h0, 10'h0, 4'd3, 5'd3, 2'b10};
        n_total++; if (obs !== exp) $display("FAIL abort_4th_mac: got %h exp %h", obs, exp); else n_pass++;
        abort = 1;
        tick(); abort = 0;
        n_total++; if (obs !== 41'h0) $display("FAIL abort_idle: got %h exp %h", obs, 41'h0); else n_pass++;
        seen_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            seen_done |= done;
        end
        n_total++; if (seen_done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done: got done_seen=%b busy=%b exp 0 0", seen_done, busy); else n_pass++;
        start = 1; abort = 1;
        tick(); start = 0; abort = 0;
        n_total++; if (obs !== 41'h0) $display("FAIL abort_beats_start: got %h exp %h", obs, 41'h0); else n_pass++;
        tick();
        n_total++; if (obs !== 41'h0) $display("FAIL abort_start_stay_idle: got %h exp %h", obs, 41'h0); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [40:0] exp;
        start = 1; cfg_acc_clear = 1; cfg_bcast = 0; cfg_pe_mask = 10'h3FF;
        for (int c = 1; c <= 5; c++) begin
            tick(); start = 0;
        end
        start = 1; cfg_bcast = 1; cfg_acc_clear = 0; cfg_pe_mask = 10'h0F0;
        tick();
        start = 0; cfg_bcast = 0; cfg_acc_clear = 1; cfg_pe_mask = 10'h3FF;
        exp = {10'h3FF, 10'h0, 10'h0, 4'd4, 5'd4, 2'b10};
        n_total++; if (obs !== exp) $display("FAIL b2b_mid_mac_start_ignored: got %h exp %h", obs, exp); else n_pass++;
        for (int c = 7; c <= 13; c++) tick();
        exp = {30'h0, 4'd8, 5'd8, 2'b11};
        n_total++; if (obs !== exp) $display("FAIL b2b_first_done: got %h exp %h", obs, exp); else n_pass++;
        start = 1;
        tick(); start = 0;
        exp = {10'h0, 10'h0, 10'h3FF, 4'd0, 5'd0, 2'b10};
        n_total++; if (obs !== exp) $display("FAIL b2b_second_clear: got %h exp %h", obs, exp); else n_pass++;
        for (int c = 2; c <= 12; c++) begin
            tick();
            n_total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_busy_c%0d: got %b exp 10", c, {busy, done}); else n_pass++;
        end
        tick();
        n_total++; if ({busy, done} !== 2'b11) $display("FAIL b2b_second_done: got %b exp 11", {busy, done}); else n_pass++;
        tick();
    endtask

    task automatic test_pipe_lat0;
        logic [40:0] exp;
        start = 1; cfg_acc_clear = 0; cfg_bcast = 0; cfg_pe_mask = 10'h3FF;
        for (int t = 0; t < 9; t++) begin
            tick(); start = 0;
        end
        exp = {10'h3FF, 10'h0, 10'h0, 4'd8, 5'd8, 2'b10};
        n_total++; if (obs0 !== exp) $display("FAIL lat0_last_tap: got %h exp %h", obs0, exp); else n_pass++;
        tick();
        exp = {30'h0, 4'd8, 5'd8, 2'b11};
        n_total++; if (obs0 !== exp) $display("FAIL lat0_done_after_tap: got %h exp %h", obs0, exp); else n_pass++;
        tick();
        n_total++; if (obs0 !== 41'h0) $display("FAIL lat0_idle: got %h exp %h", obs0, 41'h0); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_async_reset;
        logic seen_done;
        start = 1; cfg_acc_clear = 0; cfg_bcast = 0; cfg_pe_mask = 10'h3FF;
        for (int t = 0; t < 3; t++) begin
            tick(); start = 0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (obs !== 41'h0) $display("FAIL async_reset_now: got %h exp %h", obs, 41'h0); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen_done |= done | busy;
        end
        n_total++; if (seen_done !== 1'b0 || obs !== 41'h0) $display("FAIL async_reset_after: got busy_or_done=%b obs=%h exp 0", seen_done, obs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clear_pass();
        test_bcast();
        test_mask();
        test_abort();
        test_back_to_back();
        test_pipe_lat0();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
